mem_access_unit: RTL and testbench

Parametrised memory access unit that replaces the loose MAR/MDR/trap-address-mux wiring between the control unit and the byte-addressed RAM. It latches an address and store data on a single request, runs the MFA/MFC handshake to memory, checks alignment and size, sign- or zero-extends loads, aborts hung accesses with a timeout, and can override the address with a trap vector for exception fetches. It sits between the control unit/ALU and the RAM port.

---
 rtl/mem_access_unit.sv | 156 +++++++++++++++
 tb/tb_mem_access_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory access unit: latches MAR/MDR on a request, runs the MFA/MFC handshake,
// checks size/alignment, extends loads and aborts hung accesses on timeout.
module mem_access_unit #(
  parameter int unsigned             ADDR_WIDTH = 9,
  parameter int unsigned             DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]   TRAP_ADDR  = '0,
  parameter int unsigned             TIMEOUT    = 15
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  rw,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic                  trap,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  fault,
  output logic [1:0]            fault_code,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_rw,
  output logic [1:0]            mem_size,
  output logic                  mem_mfa,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_mfc
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TLAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   mar_q, mar_d;
  logic [DATA_WIDTH-1:0]   mdr_q, mdr_d;
  logic                    rw_q, rw_d;
  logic [1:0]              size_q, size_d;
  logic                    sext_q, sext_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    fault_q, fault_d;
  logic [1:0]              code_q, code_d;

  logic [ADDR_WIDTH-1:0]   eff_addr;
  logic [1:0]              eff_size;
  logic                    bad_size, misaligned;
  logic [DATA_WIDTH-1:0]   ext_data;

  // Trap fetches override the caller's address, size and direction.
  assign eff_addr   = trap ? TRAP_ADDR : addr;
  assign eff_size   = trap ? 2'b10 : size;
  assign bad_size   = (eff_size == 2'b11);
  assign misaligned = ((eff_size == 2'b01) && eff_addr[0]) ||
                      ((eff_size == 2'b10) && (eff_addr[1:0] != 2'b00));

  always_comb begin
    ext_data = mem_rdata;
    unique case (size_q)
      2'b00:   ext_data = {{(DATA_WIDTH-8){sext_q & mem_rdata[7]}}, mem_rdata[7:0]};
      2'b01:   ext_data = {{(DATA_WIDTH-16){sext_q & mem_rdata[15]}}, mem_rdata[15:0]};
      default: ext_data = {{(DATA_WIDTH-32){sext_q & mem_rdata[31]}}, mem_rdata[31:0]};
    endcase
  end

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    rw_d    = rw_q;
    size_d  = size_q;
    sext_d  = sext_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    code_d  = code_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          mar_d   = eff_addr;
          mdr_d   = wdata;
          rw_d    = trap ? 1'b1 : rw;
          size_d  = eff_size;
          sext_d  = sign_ext;
          cnt_d   = '0;
          fault_d = 1'b0;
          code_d  = 2'b00;
          if (bad_size) begin
            fault_d = 1'b1;
            code_d  = 2'b11;
            state_d = StDone;
          end else if (misaligned) begin
            fault_d = 1'b1;
            code_d  = 2'b01;
            state_d = StDone;
          end else begin
            state_d = StAccess;
          end
        end
      end
      StAccess: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_mfc) begin
          if (rw_q) rdata_d = ext_data;
          state_d = StDone;
        end else if ((TIMEOUT != 0) && (cnt_q == TLAST)) begin
          fault_d = 1'b1;
          code_d  = 2'b10;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      mar_q   <= '0;
      mdr_q   <= '0;
      rw_q    <= 1'b0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      code_q  <= code_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign mem_mfa    = (state_q == StAccess);
  assign fault      = fault_q;
  assign fault_code = code_q;
  assign rdata      = rdata_q;
  assign mem_addr   = mar_q;
  assign mem_wdata  = mdr_q;
  assign mem_rw     = rw_q;
  assign mem_size   = size_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table plus reset/busy corner sequences.
module tb_mem_access_unit;

  logic        Clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0, rw = 1'b0, sign_ext = 1'b0, trap = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [8:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, fault, mem_rw, mem_mfa;
  logic [1:0]  fault_code, mem_size;
  logic [31:0] rdata, mem_wdata;
  logic [8:0]  mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        mem_mfc = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  mem_access_unit dut (
    .Clk(Clk), .reset(reset), .req(req), .rw(rw), .size(size), .sign_ext(sign_ext),
    .trap(trap), .addr(addr), .wdata(wdata), .busy(busy), .done(done), .fault(fault),
    .fault_code(fault_code), .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rw(mem_rw), .mem_size(mem_size), .mem_mfa(mem_mfa), .mem_rdata(mem_rdata),
    .mem_mfc(mem_mfc)
  );

  typedef struct {
    string       name;
    logic        rw;
    logic [1:0]  size;
    logic        sext;
    logic        trap;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] mdata;
    int          waits;     // -1: memory never answers
    int          exp_lat;   // negedges after the accepting edge until done is seen
    int          exp_mfa;
    logic        exp_fault;
    logic [1:0]  exp_code;
    logic [31:0] exp_rdata;
    logic [8:0]  exp_maddr;
    logic        exp_mrw;
    logic [1:0]  exp_msize;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    int lat = 0;
    int mfa_n = 0;
    @(negedge Clk);
    req = 1'b1; rw = v.rw; size = v.size; sign_ext = v.sext; trap = v.trap;
    addr = v.addr; wdata = v.wdata; mem_rdata = v.mdata; mem_mfc = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    req = 1'b0; trap = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (done) begin
        lat = n;
        break;
      end
      if (mem_mfa) begin
        mfa_n++;
        if (v.waits >= 0 && mfa_n > v.waits) mem_mfc = 1'b1;
      end
      @(negedge Clk);
    end
    mem_mfc = 1'b0;
    chk({v.name, ".latency"}, lat, v.exp_lat);
    chk({v.name, ".mfa_cycles"}, mfa_n, v.exp_mfa);
    chk({v.name, ".fault"}, {31'b0, fault}, {31'b0, v.exp_fault});
    chk({v.name, ".fault_code"}, {30'b0, fault_code}, {30'b0, v.exp_code});
    chk({v.name, ".rdata"}, rdata, v.exp_rdata);
    chk({v.name, ".mem_addr"}, {23'b0, mem_addr}, {23'b0, v.exp_maddr});
    chk({v.name, ".mem_rw"}, {31'b0, mem_rw}, {31'b0, v.exp_mrw});
    chk({v.name, ".mem_size"}, {30'b0, mem_size}, {30'b0, v.exp_msize});
    chk({v.name, ".mem_wdata"}, mem_wdata, v.wdata);
    @(negedge Clk);
    chk({v.name, ".done_one_cycle"}, {31'b0, done}, 32'd0);
    chk({v.name, ".idle_after"}, {31'b0, busy}, 32'd0);
  endtask

  vec_t vecs[12];

  initial begin
    //         name      rw    size  sx    tr    addr    wdata          mdata         wt lat mfa flt   code  rdata          maddr   mrw   msize
    vecs[0]  = '{"wrd_rd", 1'b1, 2'b10, 1'b0, 1'b0, 9'h010, 32'h0,         32'h800000F0,  0,  2,  1, 1'b0, 2'b00, 32'h800000F0, 9'h010, 1'b1, 2'b10};
    vecs[1]  = '{"byte_sx", 1'b1, 2'b00, 1'b1, 1'b0, 9'h003, 32'h0,        32'h00000080,  3,  5,  4, 1'b0, 2'b00, 32'hFFFFFF80, 9'h003, 1'b1, 2'b00};
    vecs[2]  = '{"byte_zx", 1'b1, 2'b00, 1'b0, 1'b0, 9'h003, 32'h0,        32'h00000080,  3,  5,  4, 1'b0, 2'b00, 32'h00000080, 9'h003, 1'b1, 2'b00};
    vecs[3]  = '{"half_mis", 1'b0, 2'b01, 1'b0, 1'b0, 9'h005, 32'h1234,    32'hAAAAAAAA,  0,  1,  0, 1'b1, 2'b01, 32'h00000080, 9'h005, 1'b0, 2'b01};
    vecs[4]  = '{"badsize", 1'b1, 2'b11, 1'b0, 1'b0, 9'h001, 32'h0,        32'hAAAAAAAA,  0,  1,  0, 1'b1, 2'b11, 32'h00000080, 9'h001, 1'b1, 2'b11};
    vecs[5]  = '{"timeout", 1'b1, 2'b10, 1'b0, 1'b0, 9'h020, 32'h0,        32'hAAAAAAAA, -1, 16, 15, 1'b1, 2'b10, 32'h00000080, 9'h020, 1'b1, 2'b10};
    vecs[6]  = '{"trap",    1'b0, 2'b00, 1'b0, 1'b1, 9'h1FF, 32'h0,        32'h12345678,  1,  3,  2, 1'b0, 2'b00, 32'h12345678, 9'h000, 1'b1, 2'b10};
    vecs[7]  = '{"half_sx", 1'b1, 2'b01, 1'b1, 1'b0, 9'h006, 32'h0,        32'h00008001,  0,  2,  1, 1'b0, 2'b00, 32'hFFFF8001, 9'h006, 1'b1, 2'b01};
    vecs[8]  = '{"wrd_wr",  1'b0, 2'b10, 1'b0, 1'b0, 9'h004, 32'hDEADBEEF, 32'hAAAAAAAA,  2,  4,  3, 1'b0, 2'b00, 32'hFFFF8001, 9'h004, 1'b0, 2'b10};
    vecs[9]  = '{"bad_prio", 1'b1, 2'b11, 1'b0, 1'b0, 9'h003, 32'h0,       32'hAAAAAAAA,  0,  1,  0, 1'b1, 2'b11, 32'hFFFF8001, 9'h003, 1'b1, 2'b11};
    vecs[10] = '{"wrd_mis", 1'b1, 2'b10, 1'b0, 1'b0, 9'h002, 32'h0,        32'hAAAAAAAA,  0,  1,  0, 1'b1, 2'b01, 32'hFFFF8001, 9'h002, 1'b1, 2'b10};
    vecs[11] = '{"byte_hi", 1'b1, 2'b00, 1'b0, 1'b0, 9'h0FF, 32'h0,        32'hFFFFFFFE,  0,  2,  1, 1'b0, 2'b00, 32'h000000FE, 9'h0FF, 1'b1, 2'b00};

    // Reset values while reset is held.
    #1;
    chk("rst.busy", {31'b0, busy}, 32'd0);
    chk("rst.done", {31'b0, done}, 32'd0);
    chk("rst.mfa", {31'b0, mem_mfa}, 32'd0);
    chk("rst.fault", {29'b0, fault, fault_code}, 32'd0);
    chk("rst.rdata", rdata, 32'd0);
    chk("rst.mem", {mem_rw, mem_size, mem_addr}, 32'd0);
    repeat (2) @(negedge Clk);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) run(vecs[i]);

    // req during ACCESS and during DONE is ignored.
    @(negedge Clk);
    req = 1'b1; rw = 1'b1; size = 2'b10; addr = 9'h040; mem_rdata = 32'h55;
    @(posedge Clk);
    @(negedge Clk);
    addr = 9'h080;
    chk("busy.mfa", {31'b0, mem_mfa}, 32'd1);
    chk("busy.addr_access", {23'b0, mem_addr}, 32'h040);
    mem_mfc = 1'b1;
    @(negedge Clk);
    mem_mfc = 1'b0;
    chk("busy.done", {31'b0, done}, 32'd1);
    chk("busy.rdata", rdata, 32'h55);
    chk("busy.addr_done", {23'b0, mem_addr}, 32'h040);
    @(negedge Clk);
    chk("busy.not_accepted", {31'b0, busy}, 32'd0);
    chk("busy.addr_idle", {23'b0, mem_addr}, 32'h040);
    req = 1'b0;

    // Asynchronous reset in the middle of an access.
    @(negedge Clk);
    req = 1'b1; rw = 1'b1; size = 2'b10; addr = 9'h100; wdata = 32'hCAFE;
    @(posedge Clk);
    @(negedge Clk);
    req = 1'b0;
    @(negedge Clk);
    chk("arst.mfa_before", {31'b0, mem_mfa}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst.mfa", {31'b0, mem_mfa}, 32'd0);
    chk("arst.busy", {31'b0, busy}, 32'd0);
    chk("arst.rdata", rdata, 32'd0);
    chk("arst.mem_addr", {23'b0, mem_addr}, 32'd0);
    chk("arst.mem_wdata", mem_wdata, 32'd0);
    chk("arst.mem_ctl", {27'b0, mem_rw, mem_size, fault, done}, 32'd0);
    @(negedge Clk);
    reset = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge Clk);
      chk("arst.no_done", {31'b0, done | busy}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
